// File: rtl/bwd_ctrl_pipe.sv
// Elastic backward-extension control pipeline: carries per-read context, splits finish tokens from BWT occurrence-line requests.
// Latency: STAGES cycles from presentation to req_valid/fin_valid; query-ahead strobe one cycle before req_valid.
// Backpressure: per-stage valid/ready; ready ripples combinationally from req_ready/fin_ready to in_ready, strict FIFO order.
module bwd_ctrl_pipe #(
    parameter int         READ_NUM_WIDTH = 6,
    parameter int         POS_WIDTH      = 7,
    parameter int         STAGES         = 3,
    parameter int         MEM_ADDR_WIDTH = 42,
    parameter int         LINE_SHIFT     = 7,
    parameter logic [5:0] FINISH_CODE    = 6'h3F
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [READ_NUM_WIDTH-1:0]     in_read_num,
    input  logic [5:0]                    in_status,
    input  logic [POS_WIDTH-1:0]          in_pos,
    input  logic [POS_WIDTH-1:0]          in_mem_size,
    input  logic [63:0]                   in_k,
    input  logic [63:0]                   in_l,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [READ_NUM_WIDTH-1:0]     req_read_num,
    output logic [POS_WIDTH-1:0]          req_pos,
    output logic [63:0]                   req_k,
    output logic [63:0]                   req_l,
    output logic [MEM_ADDR_WIDTH-1:0]     req_addr_k,
    output logic [MEM_ADDR_WIDTH-1:0]     req_addr_l,
    output logic                          req_same_line,
    output logic                          fin_valid,
    input  logic                          fin_ready,
    output logic [READ_NUM_WIDTH-1:0]     fin_read_num,
    output logic [POS_WIDTH-1:0]          fin_mem_size,
    output logic                          q_valid,
    output logic [READ_NUM_WIDTH-1:0]     q_read_num,
    output logic [POS_WIDTH-1:0]          q_pos,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int LAST  = STAGES - 1;
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam logic [STAGES-1:0] ALL_ONES = '1;

    typedef struct packed {
        logic [READ_NUM_WIDTH-1:0] read_num;
        logic [5:0]                status;
        logic [POS_WIDTH-1:0]      pos;
        logic [POS_WIDTH-1:0]      mem_size;
        logic [63:0]               k;
        logic [63:0]               l;
    } tok_t;

    tok_t                      stg_dat [STAGES];
    tok_t                      src_dat [STAGES];
    logic [STAGES-1:0]         stg_vld;
    logic [STAGES-1:0]         src_vld;
    logic [STAGES-1:0]         stg_load;
    logic [STAGES-1:0]         vld_nxt;
    logic [MEM_ADDR_WIDTH-1:0] addr_k_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_l_q;
    logic [OCC_W-1:0]          occ_q;
    logic                      go;
    logic                      last_fin;
    logic                      out_move;

    assign go       = rst & ~flush;
    assign last_fin = (stg_dat[LAST].status == FINISH_CODE);
    assign out_move = stg_vld[LAST] & go & (last_fin ? fin_ready : req_ready);

    always_comb begin
        src_dat[0] = {in_read_num, in_status, in_pos, in_mem_size, in_k, in_l};
        src_vld[0] = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            src_dat[s] = stg_dat[s-1];
            src_vld[s] = stg_vld[s-1];
        end
    end

    // A stage can load iff some stage at or after it is empty, or the head leaves;
    // this closed form avoids a combinational chain through the load vector.
    always_comb begin
        stg_load = '0;
        vld_nxt  = '0;
        for (int s = 0; s < STAGES; s++) begin
            stg_load[s] = (|(~stg_vld & (ALL_ONES << s))) | out_move;
            vld_nxt[s]  = stg_load[s] ? src_vld[s] : stg_vld[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stg_vld  <= '0;
            occ_q    <= '0;
            addr_k_q <= '0;
            addr_l_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stg_dat[s] <= '0;
            end
        end else if (flush) begin
            stg_vld <= '0;
            occ_q   <= '0;
        end else begin
            stg_vld <= vld_nxt;
            occ_q   <= OCC_W'($countones(vld_nxt));
            for (int s = 0; s < STAGES; s++) begin
                if (stg_load[s]) begin
                    stg_dat[s] <= src_dat[s];
                end
            end
            // l is an exclusive bound, so the last occurrence needed is at l-1 (wraps for l = 0)
            if (stg_load[LAST]) begin
                addr_k_q <= MEM_ADDR_WIDTH'(src_dat[LAST].k >> LINE_SHIFT);
                addr_l_q <= MEM_ADDR_WIDTH'(64'(src_dat[LAST].l - 64'd1) >> LINE_SHIFT);
            end
        end
    end

    assign in_ready      = stg_load[0] & go;

    assign req_valid     = stg_vld[LAST] & ~last_fin & go;
    assign req_read_num  = stg_dat[LAST].read_num;
    assign req_pos       = stg_dat[LAST].pos;
    assign req_k         = stg_dat[LAST].k;
    assign req_l         = stg_dat[LAST].l;
    assign req_addr_k    = addr_k_q;
    assign req_addr_l    = addr_l_q;
    assign req_same_line = (addr_k_q == addr_l_q);

    assign fin_valid     = stg_vld[LAST] & last_fin & go;
    assign fin_read_num  = stg_dat[LAST].read_num;
    assign fin_mem_size  = stg_dat[LAST].mem_size;

    assign q_valid       = stg_vld[LAST-1] & (stg_dat[LAST-1].status != FINISH_CODE)
                         & stg_load[LAST] & go;
    assign q_read_num    = stg_dat[LAST-1].read_num;
    assign q_pos         = stg_dat[LAST-1].pos;

    assign occupancy     = occ_q;

endmodule

// File: tb/tb_bwd_ctrl_pipe.sv
// Directed bench for bwd_ctrl_pipe: address vector table plus hand-written throughput, stall, finish, flush and reset sequences.
module tb_bwd_ctrl_pipe;

    localparam int RW  = 6;
    localparam int PW  = 7;
    localparam int ST  = 3;
    localparam int MAW = 42;
    localparam int LS  = 7;

    logic           clk = 1'b0;
    logic           rst, flush;
    logic           in_valid, in_ready;
    logic [RW-1:0]  in_read_num;
    logic [5:0]     in_status;
    logic [PW-1:0]  in_pos, in_mem_size;
    logic [63:0]    in_k, in_l;
    logic           req_valid, req_ready;
    logic [RW-1:0]  req_read_num;
    logic [PW-1:0]  req_pos;
    logic [63:0]    req_k, req_l;
    logic [MAW-1:0] req_addr_k, req_addr_l;
    logic           req_same_line;
    logic           fin_valid, fin_ready;
    logic [RW-1:0]  fin_read_num;
    logic [PW-1:0]  fin_mem_size;
    logic           q_valid;
    logic [RW-1:0]  q_read_num;
    logic [PW-1:0]  q_pos;
    logic [1:0]     occupancy;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [5:0]     status;
        logic [PW-1:0]  mem_size;
        logic [63:0]    k;
        logic [63:0]    l;
        logic [MAW-1:0] ak;
        logic [MAW-1:0] al;
        logic           same;
        logic           fin;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    bwd_ctrl_pipe #(
        .READ_NUM_WIDTH(RW), .POS_WIDTH(PW), .STAGES(ST),
        .MEM_ADDR_WIDTH(MAW), .LINE_SHIFT(LS), .FINISH_CODE(6'h3F)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_read_num(in_read_num), .in_status(in_status), .in_pos(in_pos),
        .in_mem_size(in_mem_size), .in_k(in_k), .in_l(in_l),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read_num(req_read_num), .req_pos(req_pos), .req_k(req_k), .req_l(req_l),
        .req_addr_k(req_addr_k), .req_addr_l(req_addr_l), .req_same_line(req_same_line),
        .fin_valid(fin_valid), .fin_ready(fin_ready),
        .fin_read_num(fin_read_num), .fin_mem_size(fin_mem_size),
        .q_valid(q_valid), .q_read_num(q_read_num), .q_pos(q_pos),
        .occupancy(occupancy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!(req_valid || fin_valid) && lat < 10) begin
            cyc();
            lat++;
        end
    endtask

    task automatic drive(input int rn, input int st, input int pos, input int ms,
                         input logic [63:0] k, input logic [63:0] l);
        in_valid    = 1'b1;
        in_read_num = RW'(rn);
        in_status   = 6'(st);
        in_pos      = PW'(pos);
        in_mem_size = PW'(ms);
        in_k        = k;
        in_l        = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        tbl[0] = '{6'd2,  7'd0,    64'h180,              64'h200,    42'd3,            42'd3,            1'b1, 1'b0};
        tbl[1] = '{6'd2,  7'd0,    64'h180,              64'h0,      42'd3,            42'h3FFFFFFFFFF,  1'b0, 1'b0};
        tbl[2] = '{6'd2,  7'd0,    64'h1000,             64'h1081,   42'h20,           42'h21,           1'b0, 1'b0};
        tbl[3] = '{6'd5,  7'd0,    64'h12345,            64'h12380,  42'h246,          42'h246,          1'b1, 1'b0};
        tbl[4] = '{6'h3F, 7'h55,   64'h5,                64'h9,      42'd0,            42'd0,            1'b0, 1'b1};
        tbl[5] = '{6'd1,  7'd0,    64'hFFFFFFFFFFFFFFFF, 64'h1,      42'h3FFFFFFFFFF,  42'd0,            1'b0, 1'b0};
        tbl[6] = '{6'd2,  7'd0,    64'h0000020000000080, 64'h81,     42'h400000001,    42'd1,            1'b0, 1'b0};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_read_num = '0; in_status = '0;
        in_pos = '0; in_mem_size = '0; in_k = '0; in_l = '0; req_ready = 1'b1; fin_ready = 1'b1;

        // reset state
        cyc(); cyc();
        check("rst_in_ready", in_ready, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_fin_valid", fin_valid, 0);
        check("rst_q_valid", q_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_req_k", req_k, 0);
        check("rst_req_addr_l", req_addr_l, 0);
        check("rst_fin_mem_size", fin_mem_size, 0);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // address / steering table, one token at a time
        for (int i = 0; i < 7; i++) begin
            drive(i, int'(tbl[i].status), i, int'(tbl[i].mem_size), tbl[i].k, tbl[i].l);
            cyc();
            in_valid = 1'b0;
            wait_out(lat);
            check($sformatf("tbl%0d_latency", i), lat, ST - 1);
            check($sformatf("tbl%0d_req_valid", i), req_valid, !tbl[i].fin);
            check($sformatf("tbl%0d_fin_valid", i), fin_valid, tbl[i].fin);
            if (!tbl[i].fin) begin
                check($sformatf("tbl%0d_addr_k", i), req_addr_k, tbl[i].ak);
                check($sformatf("tbl%0d_addr_l", i), req_addr_l, tbl[i].al);
                check($sformatf("tbl%0d_same_line", i), req_same_line, tbl[i].same);
                check($sformatf("tbl%0d_req_pos", i), req_pos, i);
                check($sformatf("tbl%0d_req_read_num", i), req_read_num, i);
            end else begin
                check($sformatf("tbl%0d_fin_mem_size", i), fin_mem_size, tbl[i].mem_size);
                check($sformatf("tbl%0d_fin_read_num", i), fin_read_num, i);
            end
            cyc();
        end
        cyc(); cyc();
        check("drain_occupancy", occupancy, 0);

        // back-to-back throughput with query-ahead
        for (int c = 0; c < 12; c++) begin
            drive(c, 2, c, 0, 64'(c * 128), 64'(c * 128 + 1));
            in_valid = (c < 8);
            #1;
            check($sformatf("tp%0d_in_ready", c), in_ready, 1);
            check($sformatf("tp%0d_req_valid", c), req_valid, (c >= ST && c <= ST + 7));
            if (c >= ST && c <= ST + 7) check($sformatf("tp%0d_req_pos", c), req_pos, c - ST);
            check($sformatf("tp%0d_q_valid", c), q_valid, (c >= ST - 1 && c <= ST + 6));
            if (c >= ST - 1 && c <= ST + 6) check($sformatf("tp%0d_q_pos", c), q_pos, c - ST + 1);
            if (c >= ST && c <= 8) check($sformatf("tp%0d_occupancy", c), occupancy, ST);
            cyc();
        end
        in_valid = 1'b0;
        cyc();

        // output stall: fill, hold, then release with simultaneous accept
        req_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            drive(p, 2, 10 + p, 0, 64'((10 + p) * 128), 64'((10 + p) * 128 + 1));
            #1;
            check($sformatf("bp_fill%0d_in_ready", p), in_ready, 1);
            cyc();
        end
        drive(3, 2, 13, 0, 64'(13 * 128), 64'(13 * 128 + 1));
        for (int h = 0; h < 3; h++) begin
            #1;
            check($sformatf("bp_hold%0d_in_ready", h), in_ready, 0);
            check($sformatf("bp_hold%0d_occupancy", h), occupancy, 3);
            check($sformatf("bp_hold%0d_req_valid", h), req_valid, 1);
            check($sformatf("bp_hold%0d_req_pos", h), req_pos, 10);
            check($sformatf("bp_hold%0d_req_addr_k", h), req_addr_k, 10);
            cyc();
        end
        req_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_req_pos", req_pos, 10);
        cyc();
        in_valid = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            #1;
            check($sformatf("bp_drain%0d_req_valid", d), req_valid, 1);
            check($sformatf("bp_drain%0d_req_pos", d), req_pos, 10 + d);
            if (d == 1) check("bp_drain_occupancy", occupancy, 3);
            cyc();
        end
        #1;
        check("bp_empty_req_valid", req_valid, 0);

        // finish token stalled at the head blocks the following request
        fin_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(j + 1, (j == 1) ? 6'h3F : 6'd2, 20 + j, 8'h11 * (j + 1), 64'h400, 64'h480);
            #1;
            check($sformatf("fm_in%0d_in_ready", j), in_ready, 1);
            if (j == 2) begin
                check("fm_q_valid_first", q_valid, 1);
                check("fm_q_pos_first", q_pos, 20);
            end
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("fm_head_req_valid", req_valid, 1);
        check("fm_head_req_pos", req_pos, 20);
        check("fm_no_q_for_fin", q_valid, 0);
        cyc();
        for (int w = 0; w < 5; w++) begin
            #1;
            check($sformatf("fm_wait%0d_fin_valid", w), fin_valid, 1);
            check($sformatf("fm_wait%0d_req_valid", w), req_valid, 0);
            check($sformatf("fm_wait%0d_mem_size", w), fin_mem_size, 7'h22);
            check($sformatf("fm_wait%0d_read_num", w), fin_read_num, 2);
            check($sformatf("fm_wait%0d_q_valid", w), q_valid, 0);
            check($sformatf("fm_wait%0d_occupancy", w), occupancy, 2);
            cyc();
        end
        fin_ready = 1'b1;
        #1;
        check("fm_go_fin_valid", fin_valid, 1);
        check("fm_go_q_valid", q_valid, 1);
        check("fm_go_q_pos", q_pos, 22);
        cyc();
        check("fm_last_req_valid", req_valid, 1);
        check("fm_last_req_pos", req_pos, 22);
        check("fm_last_fin_valid", fin_valid, 0);
        cyc();
        check("fm_empty_occupancy", occupancy, 0);

        // flush with a full pipe
        req_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            drive(p, 2, 30 + p, 0, 64'((30 + p) * 128), 64'h1);
            cyc();
        end
        check("fl_full_occupancy", occupancy, 3);
        req_ready = 1'b1;
        flush     = 1'b1;
        drive(7, 2, 33, 0, 64'h0, 64'h1);
        #1;
        check("fl_req_valid", req_valid, 0);
        check("fl_fin_valid", fin_valid, 0);
        check("fl_in_ready", in_ready, 0);
        check("fl_q_valid", q_valid, 0);
        cyc();
        flush = 1'b0;
        drive(8, 2, 34, 0, 64'h0, 64'h1);
        #1;
        check("fl_after_occupancy", occupancy, 0);
        check("fl_after_req_valid", req_valid, 0);
        check("fl_after_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        wait_out(lat);
        check("fl_new_latency", lat, ST - 1);
        check("fl_new_req_pos", req_pos, 34);
        cyc(); cyc();

        // reset mid-stream discards two in-flight tokens
        for (int p = 0; p < 2; p++) begin
            drive(p + 9, 2, 40 + p, 5, 64'h12345, 64'h23456);
            cyc();
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("mr_in_ready_low", in_ready, 0);
        check("mr_req_valid_low", req_valid, 0);
        cyc();
        rst = 1'b1;
        #1;
        check("mr_req_valid", req_valid, 0);
        check("mr_fin_valid", fin_valid, 0);
        check("mr_q_valid", q_valid, 0);
        check("mr_occupancy", occupancy, 0);
        check("mr_req_pos", req_pos, 0);
        check("mr_req_k", req_k, 0);
        check("mr_req_addr_k", req_addr_k, 0);
        check("mr_req_read_num", req_read_num, 0);
        check("mr_fin_mem_size", fin_mem_size, 0);
        for (int w = 0; w < 6; w++) begin
            check($sformatf("mr_quiet%0d", w), req_valid | fin_valid, 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
